nes_controller_emulator: RTL and testbench

- Responder end of the NES controller serial protocol; mimics a 4021-based NES pad on the latch/pulse/data wires.
- The datapath's controller poller is the host: it drives latch and pulse and samples data.
- Parallel button inputs (FPGA switches or a bench model) are captured on latch and shifted out on pulse, active-low, A first.
- Used for on-board testing without a physical pad and as the reference responder in datapath verification.

---
 rtl/nes_controller_emulator.sv | 103 ++++++++++
 tb/tb_nes_controller_emulator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_emulator.sv
// NES pad responder: captures buttons on latch, shifts them out
// active-low on pulse rising edges, A first, then fill ones.
module nes_controller_emulator #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nes_latch,
   input  logic       nes_pulse,
   input  logic [7:0] buttons,
   output logic       nes_data,
   output logic [3:0] bit_cnt,
   output logic       frame_done,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
   logic                   latch_s, pulse_s, pulse_d;
   logic                   pulse_rise;
   logic [7:0]             sreg, sreg_n;
   logic [3:0]             cnt_n;
   logic [15:0]            tcnt, tcnt_n;
   logic [16:0]            tinc;
   logic                   fd_n, to_n;

   assign latch_s    = latch_sync[SYNC_STAGES-1];
   assign pulse_s    = pulse_sync[SYNC_STAGES-1];
   assign pulse_rise = pulse_s & ~pulse_d;
   assign tinc       = {1'b0, tcnt} + 17'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latch_sync  <= '0;
         pulse_sync  <= '0;
         pulse_d     <= 1'b0;
         state       <= IDLE;
         sreg        <= 8'hFF;
         nes_data    <= 1'b1;
         bit_cnt     <= 4'd0;
         tcnt        <= 16'd0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         latch_sync  <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
         pulse_sync  <= {pulse_sync[SYNC_STAGES-2:0], nes_pulse};
         pulse_d     <= pulse_s;
         state       <= state_n;
         sreg        <= sreg_n;
         nes_data    <= sreg[0];
         bit_cnt     <= cnt_n;
         tcnt        <= tcnt_n;
         frame_done  <= fd_n;
         timeout_err <= to_n;
      end
   end

   // Latch overrides everything, so a relatch restarts a frame mid-shift
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = bit_cnt;
      tcnt_n  = 16'd0;
      fd_n    = 1'b0;
      to_n    = 1'b0;
      if (latch_s) begin
         state_n = LOAD;
         sreg_n  = ~buttons;
         cnt_n   = 4'd0;
      end else begin
         unique case (state)
            IDLE: sreg_n = 8'hFF;
            LOAD: state_n = SHIFT;
            SHIFT: begin
               if (pulse_rise) begin
                  sreg_n = {1'b1, sreg[7:1]};
                  cnt_n  = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state_n = DONE;
                     fd_n    = 1'b1;
                  end
               end else if (tinc == 17'(TIMEOUT_CYCLES)) begin
                  state_n = IDLE;
                  sreg_n  = 8'hFF;
                  cnt_n   = 4'd0;
                  to_n    = 1'b1;
               end else begin
                  tcnt_n = tinc[15:0];
               end
            end
            DONE: begin
               sreg_n = 8'hFF;
               cnt_n  = 4'd8;
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Bench for nes_controller_emulator: table-driven frames with a
// scoreboard queue of expected serial bits, plus corner sequences.
module tb_nes_controller_emulator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       nes_latch = 1'b0, nes_pulse = 1'b0;
   logic       t_latch = 1'b0, t_pulse = 1'b0;
   logic [7:0] buttons = 8'h00;
   logic       nes_data, frame_done, timeout_err;
   logic [3:0] bit_cnt;
   logic       t_data, t_fd, t_to;
   logic [3:0] t_cnt;

   nes_controller_emulator dut (
      .clk(clk), .reset(reset), .nes_latch(nes_latch),
      .nes_pulse(nes_pulse), .buttons(buttons), .nes_data(nes_data),
      .bit_cnt(bit_cnt), .frame_done(frame_done),
      .timeout_err(timeout_err)
   );

   nes_controller_emulator #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut_t (
      .clk(clk), .reset(reset), .nes_latch(t_latch),
      .nes_pulse(t_pulse), .buttons(buttons), .nes_data(t_data),
      .bit_cnt(t_cnt), .frame_done(t_fd), .timeout_err(t_to)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int fd_cnt = 0;
   int to_cnt = 0;
   int to_stamp = -1;
   int passed = 0;
   int total = 0;
   logic sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (t_to) begin
         to_cnt++;
         to_stamp = cyc;
      end
   end

   typedef struct {
      logic [7:0] btn;
      logic [7:0] exp_bits;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic latch_frame(input logic [7:0] b);
      buttons = b;
      nes_latch = 1'b1;
      wait_cyc(8);
      nes_latch = 1'b0;
      wait_cyc(8);
   endtask

   task automatic pulse1();
      nes_pulse = 1'b1;
      wait_cyc(8);
      nes_pulse = 1'b0;
      wait_cyc(8);
   endtask

   task automatic push_frame(input logic [7:0] e);
      sb.delete();
      for (int i = 0; i < 8; i++) sb.push_back(e[i]);
      sb.push_back(1'b1);
   endtask

   task automatic check_bit(input string nm);
      logic e;
      e = sb.pop_front();
      check(nm, 32'(nes_data), 32'(e));
   endtask

   initial begin
      int fd0, c0;
      vecs[0] = '{8'h05, 8'hFA};
      vecs[1] = '{8'h00, 8'hFF};
      vecs[2] = '{8'hFF, 8'h00};
      vecs[3] = '{8'h10, 8'hEF};
      vecs[4] = '{8'h81, 8'h7E};
      vecs[5] = '{8'h5A, 8'hA5};

      wait_cyc(3);
      check("rst_data", 32'(nes_data), 32'd1);
      check("rst_cnt", 32'(bit_cnt), 32'd0);
      check("rst_fd", 32'(frame_done), 32'd0);
      check("rst_to", 32'(timeout_err), 32'd0);
      reset = 1'b0;
      wait_cyc(4);

      foreach (vecs[v]) begin
         fd0 = fd_cnt;
         latch_frame(vecs[v].btn);
         push_frame(vecs[v].exp_bits);
         for (int i = 0; i < 9; i++) begin
            check_bit($sformatf("vec%0d_bit%0d", v, i));
            if (i < 8) pulse1();
         end
         check($sformatf("vec%0d_cnt", v), 32'(bit_cnt), 32'd8);
         check($sformatf("vec%0d_fd", v), 32'(fd_cnt), 32'(fd0 + 1));
      end

      fd0 = fd_cnt;
      for (int i = 0; i < 4; i++) begin
         pulse1();
         check($sformatf("over_data%0d", i), 32'(nes_data), 32'd1);
         check($sformatf("over_cnt%0d", i), 32'(bit_cnt), 32'd8);
      end
      check("over_fd", 32'(fd_cnt), 32'(fd0));

      buttons = 8'h02;
      nes_latch = 1'b1;
      nes_pulse = 1'b1;
      wait_cyc(8);
      check("simul_cnt", 32'(bit_cnt), 32'd0);
      nes_latch = 1'b0;
      nes_pulse = 1'b0;
      wait_cyc(8);
      check("simul_a", 32'(nes_data), 32'd1);
      check("simul_cnt2", 32'(bit_cnt), 32'd0);
      pulse1();
      check("simul_b", 32'(nes_data), 32'd0);
      check("simul_cnt3", 32'(bit_cnt), 32'd1);

      latch_frame(8'h10);
      push_frame(8'hEF);
      for (int i = 0; i < 3; i++) begin
         check_bit($sformatf("rl_pre%0d", i));
         pulse1();
      end
      check("rl_cnt3", 32'(bit_cnt), 32'd3);
      nes_latch = 1'b1;
      wait_cyc(8);
      check("rl_cnt0", 32'(bit_cnt), 32'd0);
      nes_latch = 1'b0;
      wait_cyc(8);
      push_frame(8'hEF);
      for (int i = 0; i < 5; i++) begin
         check_bit($sformatf("rl_bit%0d", i));
         if (i < 4) pulse1();
      end

      latch_frame(8'h05);
      for (int i = 0; i < 3; i++) pulse1();
      check("mid_cnt3", 32'(bit_cnt), 32'd3);
      fd0 = fd_cnt;
      reset = 1'b1;
      #1;
      check("mid_data", 32'(nes_data), 32'd1);
      check("mid_cnt", 32'(bit_cnt), 32'd0);
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(4);
      check("mid_fd", 32'(fd_cnt), 32'(fd0));
      check("mid_idle_data", 32'(nes_data), 32'd1);
      check("mid_idle_cnt", 32'(bit_cnt), 32'd0);

      buttons = 8'h01;
      t_latch = 1'b1;
      wait_cyc(8);
      t_latch = 1'b0;
      wait_cyc(8);
      t_pulse = 1'b1;
      wait_cyc(8);
      t_pulse = 1'b0;
      wait_cyc(8);
      c0 = cyc;
      t_pulse = 1'b1;
      wait_cyc(8);
      t_pulse = 1'b0;
      check("to_cnt2", 32'(t_cnt), 32'd2);
      check("to_none_yet", 32'(to_cnt), 32'd0);
      wait_cyc(100);
      check("to_once", 32'(to_cnt), 32'd1);
      check("to_stamp", 32'(to_stamp), 32'(c0 + 67));
      check("to_bitcnt", 32'(t_cnt), 32'd0);
      check("to_data", 32'(t_data), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
